firebird7_in_gate1_tessent_data_mux_sync: RTL

FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_SYNC -- requirements
Module: firebird7_in_gate1_tessent_data_mux_sync

---
 rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv | 24 ++
 rtl/firebird7_in_gate1_tessent_data_mux_settle_cnt.sv | 36 +++
 rtl/firebird7_in_gate1_tessent_data_mux_sync.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_data_mux_pkg
// Purpose  : Shared types and constants for the IJTAG/functional data mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package firebird7_in_gate1_tessent_data_mux_pkg;

    localparam int SETTLE_CNT_W = 4;

    localparam logic SRC_FUNC  = 1'b0;
    localparam logic SRC_IJTAG = 1'b1;

    typedef enum logic [1:0] {
        FUNC            = 2'd0,
        SETTLE_TO_IJTAG = 2'd1,
        IJTAG           = 2'd2,
        SETTLE_TO_FUNC  = 2'd3
    } mux_state_t;

endpackage : firebird7_in_gate1_tessent_data_mux_pkg

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_data_mux_settle_cnt.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_data_mux_settle_cnt
// Purpose  : Loadable saturating down-counter with zero flag for settle timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module firebird7_in_gate1_tessent_data_mux_settle_cnt
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_load,
    input  logic [SETTLE_CNT_W-1:0] i_load_val,
    input  logic                    i_dec,
    output logic                    o_zero
);

    logic [SETTLE_CNT_W-1:0] r_count;

    // Decrement saturates at zero so the counter can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule : firebird7_in_gate1_tessent_data_mux_settle_cnt

`default_nettype wire

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// ============================================================================
// Module   : firebird7_in_gate1_tessent_data_mux_sync
// Purpose  : Registered functional/IJTAG data mux with settle-timed switching.
//            Optional capture register enabled by TESSENT_DATA_MUX_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module firebird7_in_gate1_tessent_data_mux_sync
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_select,
    input  logic [WIDTH-1:0] functional_data_in,
    input  logic [WIDTH-1:0] ijtag_data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             active_src,
    output logic             switch_busy,
    output logic             switch_done
`ifdef TESSENT_DATA_MUX_CAPTURE_EN
    ,
    input  logic             ijtag_capture,
    output logic [WIDTH-1:0] captured_data
`endif
);

    localparam logic [SETTLE_CNT_W-1:0] c_load_val = SETTLE_CNT_W'(SETTLE_CYC - 1);

    mux_state_t       r_state;
    mux_state_t       w_state_next;
    logic [WIDTH-1:0] r_data;
    logic             r_active;
    logic             r_done;
    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_zero;
    logic             w_done_next;
    logic             w_load_func;
    logic             w_load_ijtag;

    firebird7_in_gate1_tessent_data_mux_settle_cnt u_settle_cnt (
        .clk        (ijtag_tck),
        .rst        (ijtag_reset),
        .i_load     (w_cnt_load),
        .i_load_val (c_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_state <= FUNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A reverted select always wins over completion, so an abort never pulses done.
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_done_next  = 1'b0;
        w_load_func  = 1'b0;
        w_load_ijtag = 1'b0;
        case (r_state)
            FUNC: begin
                w_load_func = 1'b1;
                if (ijtag_select) begin
                    w_state_next = SETTLE_TO_IJTAG;
                    w_cnt_load   = 1'b1;
                end
            end
            SETTLE_TO_IJTAG: begin
                if (!ijtag_select) begin
                    w_state_next = FUNC;
                end else if (w_cnt_zero) begin
                    w_state_next = IJTAG;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            IJTAG: begin
                w_load_ijtag = 1'b1;
                if (!ijtag_select) begin
                    w_state_next = SETTLE_TO_FUNC;
                    w_cnt_load   = 1'b1;
                end
            end
            SETTLE_TO_FUNC: begin
                if (ijtag_select) begin
                    w_state_next = IJTAG;
                end else if (w_cnt_zero) begin
                    w_state_next = FUNC;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: begin
                w_state_next = FUNC;
            end
        endcase
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_data   <= '0;
            r_active <= SRC_FUNC;
            r_done   <= 1'b0;
        end else begin
            if (w_load_func) begin
                r_data <= functional_data_in;
            end else if (w_load_ijtag) begin
                r_data <= ijtag_data_in;
            end
            r_done <= w_done_next;
            if (w_done_next) begin
                r_active <= (r_state == SETTLE_TO_IJTAG) ? SRC_IJTAG : SRC_FUNC;
            end
        end
    end

`ifdef TESSENT_DATA_MUX_CAPTURE_EN
    logic [WIDTH-1:0] r_captured;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_captured <= '0;
        end else if (ijtag_capture) begin
            r_captured <= functional_data_in;
        end
    end

    assign captured_data = r_captured;
`endif

    assign data_out    = r_data;
    assign active_src  = r_active;
    assign switch_done = r_done;
    assign switch_busy = (r_state == SETTLE_TO_IJTAG) || (r_state == SETTLE_TO_FUNC);

endmodule : firebird7_in_gate1_tessent_data_mux_sync

`default_nettype wire
